// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, using
// a single full-adder slice.
//
// Operation:
//   - start (sampled in IDLE) loads the operands and the mode.
//   - WIDTH ADD cycles follow, one per result bit.
//   - A one-cycle DONE state raises done.
//   - The block then returns to IDLE.
//   - Subtraction computes a + ~b + 1.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   begin an operation (IDLE only)
//   sub    in   0 = a+b, 1 = a-b (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   cin    in   carry-in for add mode (ignored when sub=1)
//   sum    out  registered result, stable from done until the next start
//   cout   out  carry out of MSB (sub mode: 1 = no borrow)
//   ovf    out  signed overflow (carry into MSB ^ carry out of MSB)
//   busy   out  high in ADD and DONE
//   done   out  one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic               slice_sum;
   logic               slice_carry;
   logic               last_bit;

   // Full-adder slice on the current LSBs and the running carry.
   assign slice_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign slice_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
   assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)    state_d = S_ADD;
         S_ADD:   if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------------------
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: invert B and force the carry-in.
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
            end
         end

         S_ADD: begin
            sum_d   = {slice_sum, sum_q[WIDTH-1:1]};
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = slice_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               // carry_q here is the carry into the MSB.
               cout_d = slice_carry;
               ovf_d  = carry_q ^ slice_carry;
            end
         end

         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Self-checking bench for bit_serial_adder with WIDTH=8.
//
// Expected results come from a word-level model. They are pushed to a queue
// when an operation is started, and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;
   logic             done;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   last_done_cyc = 0;
   exp_t sb_q[$];

   bit_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Word-level reference model; overflow taken from operand/result signs.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y_in,
                                  input logic s, input logic c);
      exp_t             e;
      logic [WIDTH-1:0] y;
      logic [WIDTH:0]   r;
      y      = s ? ~y_in : y_in;
      r      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, (s ? 1'b1 : c)};
      e.sum  = r[WIDTH-1:0];
      e.cout = r[WIDTH];
      e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      return e;
   endfunction

   // Drive one operation and check its result.
   // poke_at > 0 re-pulses start with zero operands after that ADD cycle.
   // On return the DUT is back in IDLE, one cycle after done.
   task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xsub, input logic xcin, input int poke_at);
      exp_t e;
      bit   seen = 0;
      a = xa; b = xb; sub = xsub; cin = xcin; start = 1'b1;
      sb_q.push_back(model(xa, xb, xsub, xcin));
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 3 * WIDTH; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            seen = 1;
            last_done_cyc = cyc;
            check_eq("latency", 64'(i), 64'(WIDTH));
            check_eq("busy_in_done", 64'(busy), 64'(1));
            break;
         end
         if (i == poke_at) begin
            a = '0; b = '0; sub = 1'b0; cin = 1'b0; start = 1'b1;
         end
      end
      check_eq("done_seen", 64'(seen), 64'(1));
      e = sb_q.pop_front();
      check_eq("sum",  64'(sum),  64'(e.sum));
      check_eq("cout", 64'(cout), 64'(e.cout));
      check_eq("ovf",  64'(ovf),  64'(e.ovf));
      @(posedge clk); #1;
      check_eq("done_pulse_end", 64'(done), 64'(0));
      check_eq("busy_idle",      64'(busy), 64'(0));
      check_eq("sum_hold",       64'(sum),  64'(e.sum));
   endtask

   initial begin
      int d0;
      int t1;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_sum",  64'(sum),  64'(0));
      check_eq("rst_cout", 64'(cout), 64'(0));
      check_eq("rst_ovf",  64'(ovf),  64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_done", 64'(done), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors; the first is accepted on the first edge after reset.
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
      run_op(8'hFF, 8'h00, 1'b0, 1'b1, 0);
      run_op(8'h10, 8'h20, 1'b1, 1'b0, 0);
      run_op(8'h80, 8'h01, 1'b1, 1'b0, 0);
      run_op(8'h7F, 8'h7F, 1'b1, 1'b1, 0);

      // start during ADD cycle 3 is ignored; exactly one done pulse.
      d0 = done_cnt;
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 3);
      check_eq("single_done", 64'(done_cnt - d0), 64'(1));

      // Mid-operation reset aborts without a done pulse.
      d0 = done_cnt;
      a = 8'h33; b = 8'h44; sub = 1'b0; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check_eq("pre_abort_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      check_eq("abort_sum",  64'(sum),  64'(0));
      check_eq("abort_cout", 64'(cout), 64'(0));
      check_eq("abort_ovf",  64'(ovf),  64'(0));
      check_eq("abort_busy", 64'(busy), 64'(0));
      check_eq("abort_done", 64'(done), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);
      check_eq("abort_no_done", 64'(done_cnt - d0), 64'(1));

      // Back-to-back: the next start is asserted in the cycle after done.
      run_op(8'hC3, 8'h3C, 1'b0, 1'b1, 0);
      t1 = last_done_cyc;
      run_op(8'h40, 8'h40, 1'b0, 1'b0, 0);
      check_eq("b2b_gap", 64'(last_done_cyc - t1), 64'(WIDTH + 2));

      // Random operations.
      for (int k = 0; k < 8; k++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 0);
      end

      check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b (two's complement); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 cin  input  1  carry-in for add mode; sampled with start, ignored when sub=1.
REQ-009 sum  output  WIDTH  registered result; held stable from done until the next accepted start.
REQ-010 cout  output  1  final carry out of MSB; in sub mode 1 = no borrow (a>=b unsigned).
REQ-011 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-012 busy  output  1  high in ADD and DONE states.
REQ-013 done  output  1  single-cycle pulse, high in DONE state only.

Function
REQ-014 Single bit slice (sum = x^y^c, carry = x&y | c&(x^y)) processes one bit per clock, LSB first.
REQ-015 FSM states IDLE, ADD, DONE; encoding free.
REQ-016 IDLE: on edge with start=1, latch a into shift reg A, (sub ? ~b : b) into shift reg B, carry reg = (sub ? 1 : cin), bit counter = 0; go ADD.
REQ-017 IDLE with start=0: remain IDLE, all outputs hold.
REQ-018 ADD: each edge, compute slice on A[0], B[0], carry reg; shift result bit into sum MSB, shift A and B right, update carry reg, increment counter.
REQ-019 ADD: on the edge processing bit WIDTH-1, capture carry into MSB for ovf, write cout and ovf, go DONE.
REQ-020 DONE: done=1 for exactly one cycle; next edge go IDLE unconditionally.
REQ-021 Latency: start sampled on edge E0; done high after edge E0+WIDTH+1... precisely: ADD occupies edges E1..EWIDTH, done visible after edge EWIDTH, falls after edge EWIDTH+1.
REQ-022 start while busy (ADD or DONE) ignored; no queuing; operand changes while busy have no effect.
REQ-023 sum, cout, ovf hold previous result during IDLE and are not altered until the new operation's bits are shifted in; only values present while done=1 or later in IDLE are guaranteed valid.
REQ-024 Counter width = ceil(log2(WIDTH))+1; no wrap within an operation.
REQ-025 Back-to-back: start asserted in the cycle after done (IDLE) is accepted; throughput one op per WIDTH+2 cycles.

Reset
REQ-026 rst=1 forces immediately (asynchronously) state IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, counter=0, shift and carry regs 0.
REQ-027 rst asserted mid-operation aborts it; no done pulse is produced for the aborted operation.
REQ-028 First start is accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-029 Add: a=0x5A, b=0x3C, cin=0, sub=0 -> after 8 ADD cycles done=1, sum=0x96, cout=0, ovf=1.
REQ-030 Add wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-031 Sub: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-032 start pulsed again at ADD cycle 3 with a=0x00, b=0x00 -> ignored; first result delivered unchanged, done pulses once.
REQ-033 rst asserted at ADD cycle 4 -> all outputs 0 immediately, busy=0, no done; subsequent start 0x01+0x01 -> sum=0x02.
REQ-034 Back-to-back: start re-asserted in the cycle after done -> second op accepted, done pulses exactly WIDTH+2 cycles apart.
